// File: rtl/flash_cmd_decoder.sv
// Serial flash command decoder: shifts bytes MSB-first from sdaIn and decodes
// the AA,55,<cmd>[,addr[,data]] unlock sequence into one-cycle command strobes.
module flash_cmd_decoder (
  input  logic       SCL,
  input  logic       reset,
  input  logic       sdaIn,
  input  logic       frameActive,
  output logic [7:0] addrOut,
  output logic [7:0] dataOut,
  output logic       chipEraseStb,
  output logic       progStb,
  output logic       sectEraseStb,
  output logic       readStb,
  output logic       seqError,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, UNLK, CMD, ADDR, DATA, HOLD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_PROG, OP_SECT, OP_READ} op_t;

  state_t     state, state_next;
  op_t        op, op_next;
  logic [2:0] bit_cnt;
  // Only the low 7 shifted bits ever reach a completed byte, so bit 7 is not stored.
  logic [6:0] shift;
  logic [7:0] byte_val;
  logic       byte_done;
  logic       chip_d, prog_d, sect_d, read_d, err_d;
  logic       addr_load, data_load;

  assign byte_val  = {shift, sdaIn};
  assign byte_done = frameActive && (bit_cnt == 3'd7);

  always_ff @(posedge SCL or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op    <= OP_NONE;
    end else begin
      state <= state_next;
      op    <= op_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op;
    if (!frameActive) begin
      state_next = IDLE;
      op_next    = OP_NONE;
    end else if (byte_done) begin
      case (state)
        IDLE: state_next = (byte_val == 8'hAA) ? UNLK : HOLD;
        UNLK: state_next = (byte_val == 8'h55) ? CMD : HOLD;
        CMD: begin
          case (byte_val)
            8'hC0: begin
              state_next = ADDR;
              op_next    = OP_PROG;
            end
            8'hD0: begin
              state_next = ADDR;
              op_next    = OP_SECT;
            end
            8'hE0: begin
              state_next = ADDR;
              op_next    = OP_READ;
            end
            default: state_next = HOLD;
          endcase
        end
        ADDR:    state_next = (op == OP_PROG) ? DATA : HOLD;
        DATA:    state_next = HOLD;
        HOLD:    state_next = HOLD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    chip_d    = 1'b0;
    prog_d    = 1'b0;
    sect_d    = 1'b0;
    read_d    = 1'b0;
    err_d     = 1'b0;
    addr_load = 1'b0;
    data_load = 1'b0;
    busy      = (state != IDLE);
    if (byte_done) begin
      case (state)
        IDLE: err_d = (byte_val != 8'hAA);
        UNLK: err_d = (byte_val != 8'h55);
        CMD: begin
          case (byte_val)
            8'hB0:               chip_d = 1'b1;
            8'hC0, 8'hD0, 8'hE0: ;
            default:             err_d = 1'b1;
          endcase
        end
        ADDR: begin
          addr_load = 1'b1;
          sect_d    = (op == OP_SECT);
          read_d    = (op == OP_READ);
        end
        DATA: begin
          data_load = 1'b1;
          prog_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCL or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      shift        <= '0;
      addrOut      <= '0;
      dataOut      <= '0;
      chipEraseStb <= 1'b0;
      progStb      <= 1'b0;
      sectEraseStb <= 1'b0;
      readStb      <= 1'b0;
      seqError     <= 1'b0;
    end else begin
      chipEraseStb <= chip_d;
      progStb      <= prog_d;
      sectEraseStb <= sect_d;
      readStb      <= read_d;
      seqError     <= err_d;
      if (!frameActive) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= byte_val[6:0];
      end
      if (addr_load) addrOut <= byte_val;
      if (data_load) dataOut <= byte_val;
    end
  end

endmodule

// File: tb/tb_flash_cmd_decoder.sv
// Scoreboard bench for flash_cmd_decoder: a byte-level model predicts the
// strobe each frame yields; a negedge monitor pops and compares.
module tb_flash_cmd_decoder;

  logic       SCL = 1'b0;
  logic       reset, sdaIn, frameActive;
  logic [7:0] addrOut, dataOut;
  logic       chipEraseStb, progStb, sectEraseStb, readStb, seqError, busy;

  flash_cmd_decoder dut (
    .SCL         (SCL),
    .reset       (reset),
    .sdaIn       (sdaIn),
    .frameActive (frameActive),
    .addrOut     (addrOut),
    .dataOut     (dataOut),
    .chipEraseStb(chipEraseStb),
    .progStb     (progStb),
    .sectEraseStb(sectEraseStb),
    .readStb     (readStb),
    .seqError    (seqError),
    .busy        (busy)
  );

  always #5 SCL = ~SCL;

  localparam logic [4:0] K_CHIP = 5'b10000, K_PROG = 5'b01000, K_SECT = 5'b00100,
                         K_READ = 5'b00010, K_ERR = 5'b00001;

  typedef struct {
    logic [4:0]  kind;
    int unsigned bit_no;
    logic [7:0]  addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned bits_sent = 0;
  logic [7:0]  fb[8];
  int unsigned fn, fpart;
  logic [7:0]  m_addr, m_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_ev(input logic [4:0] k, input int unsigned byte_idx);
    exp_t e;
    e.kind   = k;
    e.bit_no = 8 * (byte_idx + 1);
    e.addr   = m_addr;
    e.data   = m_data;
    exp_q.push_back(e);
  endtask

  // Sequence rules applied to the complete bytes of one frame.
  task automatic model_frame();
    if (fn < 1) return;
    if (fb[0] != 8'hAA) begin push_ev(K_ERR, 0); return; end
    if (fn < 2) return;
    if (fb[1] != 8'h55) begin push_ev(K_ERR, 1); return; end
    if (fn < 3) return;
    case (fb[2])
      8'hB0: push_ev(K_CHIP, 2);
      8'hC0: if (fn >= 4) begin
        m_addr = fb[3];
        if (fn >= 5) begin
          m_data = fb[4];
          push_ev(K_PROG, 4);
        end
      end
      8'hD0: if (fn >= 4) begin m_addr = fb[3]; push_ev(K_SECT, 3); end
      8'hE0: if (fn >= 4) begin m_addr = fb[3]; push_ev(K_READ, 3); end
      default: push_ev(K_ERR, 2);
    endcase
  endtask

  always @(negedge SCL) begin : monitor
    logic [4:0] act;
    exp_t       e;
    if (!reset) begin
      act = {chipEraseStb, progStb, sectEraseStb, readStb, seqError};
      if (act != 5'b0) begin
        chk("strobe_onehot", $countones(act), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {27'b0, act}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {27'b0, act}, {27'b0, e.kind});
          chk("strobe_bit", bits_sent, e.bit_no);
          chk("strobe_addr", {24'b0, addrOut}, {24'b0, e.addr});
          chk("strobe_data", {24'b0, dataOut}, {24'b0, e.data});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge SCL);
    sdaIn       = b;
    frameActive = 1'b1;
    @(posedge SCL);
    bits_sent++;
  endtask

  task automatic end_frame();
    @(negedge SCL);
    frameActive = 1'b0;
    sdaIn       = 1'($urandom);
    @(posedge SCL);
    @(negedge SCL);
    #1;
    chk("busy_after_frame", {31'b0, busy}, 0);
    chk("addr_after_frame", {24'b0, addrOut}, {24'b0, m_addr});
    chk("data_after_frame", {24'b0, dataOut}, {24'b0, m_data});
    chk("missing_strobe", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame();
    bits_sent = 0;
    model_frame();
    for (int i = 0; i < int'(fn); i++)
      for (int j = 7; j >= 0; j--) send_bit(fb[i][j]);
    for (int j = 0; j < int'(fpart); j++) send_bit(1'($urandom));
    end_frame();
  endtask

  task automatic load(input logic [7:0] b0, b1, b2, b3, b4,
                      input int unsigned n, input int unsigned part);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
    fn = n; fpart = part;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] good, input int unsigned pct);
    return ($urandom_range(99) < pct) ? good : 8'($urandom);
  endfunction

  initial begin
    logic [7:0] cmds[4];
    cmds[0] = 8'hB0; cmds[1] = 8'hC0; cmds[2] = 8'hD0; cmds[3] = 8'hE0;
    reset = 1'b1; frameActive = 1'b0; sdaIn = 1'b0;
    m_addr = '0; m_data = '0;
    repeat (2) @(posedge SCL);
    #1;
    chk("reset_outputs", {18'b0, addrOut, dataOut, chipEraseStb, progStb,
        sectEraseStb, readStb, seqError, busy}, 0);
    @(negedge SCL);
    reset = 1'b0;

    load(8'hAA, 8'h55, 8'hC0, 8'h3C, 8'hA5, 5, 0); send_frame();
    load(8'hAA, 8'h55, 8'hD0, 8'h12, 8'h00, 4, 0); send_frame();
    load(8'hAA, 8'h55, 8'hB0, 8'hC0, 8'h00, 4, 0); send_frame();
    load(8'hAA, 8'h56, 8'h55, 8'hE0, 8'h01, 5, 0); send_frame();
    load(8'hAA, 8'h55, 8'hE0, 8'h00, 8'h00, 3, 4); send_frame();
    load(8'hAA, 8'h55, 8'hE0, 8'h7F, 8'h00, 4, 0); send_frame();
    load(8'hAA, 8'h55, 8'hC0, 8'h99, 8'h00, 4, 7); send_frame();

    for (int f = 0; f < 300; f++) begin
      fb[0] = pick(8'hAA, 85);
      fb[1] = pick(8'h55, 85);
      fb[2] = pick(cmds[$urandom_range(3)], 85);
      for (int k = 3; k < 8; k++) fb[k] = 8'($urandom);
      fn    = $urandom_range(1, 6);
      fpart = ($urandom_range(1) == 1) ? $urandom_range(1, 7) : 0;
      send_frame();
      repeat ($urandom_range(0, 2)) @(posedge SCL);
    end

    // Reset mid-command after 20 bits of AA,55,C0.
    load(8'h11, 8'h22, 8'hC0, 8'hEE, 8'h77, 5, 0); send_frame();
    load(8'hAA, 8'h55, 8'hC0, 8'h00, 8'h00, 3, 0);
    bits_sent = 0;
    for (int i = 0; i < 20; i++) send_bit(fb[i / 8][7 - (i % 8)]);
    #2 reset = 1'b1;
    #1;
    chk("midframe_reset", {18'b0, addrOut, dataOut, chipEraseStb, progStb,
        sectEraseStb, readStb, seqError, busy}, 0);
    m_addr = '0; m_data = '0;
    exp_q.delete();
    @(negedge SCL);
    frameActive = 1'b0;
    @(negedge SCL);
    reset = 1'b0;
    load(8'hAA, 8'h55, 8'hC0, 8'h5A, 8'hC3, 5, 0); send_frame();

    repeat (3) @(posedge SCL);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
